// File: rtl/dlfloat16_wb_queue.sv
// Purpose: writeback FIFO behind the DLfloat16 FPU; retires {result, rd, flags} to the regfile
//          and folds retired exception flags into a sticky, software-visible fflags register.
// Latency: 1 cycle from push to wb_valid on an empty queue (no bypass); 1 push + 1 pop per cycle.
// Backpressure: in_ready drops when count == DEPTH; wb_ready may stall the head indefinitely.
//
// Ports:
//   clk, rst            single rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake carrying in_result, in_rd, in_flags
//   wb_valid/wb_ready   downstream handshake presenting the head as wb_data, wb_rd, wb_flags
//   flush               drop every queued entry and zero the pointers
//   csr_we/csr_wdata    software write of fflags
//   fflags              sticky flags {invalid, div_by_zero, overflow, underflow, inexact}
//   count               current occupancy, 0..DEPTH
module dlfloat16_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_flags,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [31:0]                wb_data,
    output logic [4:0]                 wb_rd,
    output logic [4:0]                 wb_flags,
    input  logic                       flush,
    input  logic                       csr_we,
    input  logic [4:0]                 csr_wdata,
    output logic [4:0]                 fflags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [4:0]    fflags_q, fflags_d;
    logic [41:0]   mem_q [DEPTH];
    logic [41:0]   head;
    logic          push, pop;

    // Handshake outputs come only from the registered count, so there is no
    // combinational path from in_valid to in_ready or wb_ready to wb_valid.
    assign in_ready = (count_q != CNT_MAX);
    assign wb_valid = (count_q != '0);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = wb_valid & wb_ready & ~flush;

    assign head     = mem_q[rd_ptr_q];
    assign wb_data  = head[41:10];
    assign wb_rd    = head[9:5];
    assign wb_flags = head[4:0];

    assign fflags = fflags_q;
    assign count  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // A CSR write replaces the old value, but flags of an entry retiring in
        // the same cycle are still OR-ed in so they are never lost.
        fflags_d = (csr_we ? csr_wdata : fflags_q) | (pop ? wb_flags : 5'b0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fflags_q <= fflags_d;
        end
    end

    // Entry storage is intentionally not reset; wb_* are only meaningful with wb_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_result, in_rd, in_flags};
        end
    end

endmodule

// File: tb/tb_dlfloat16_wb_queue.sv
module tb_dlfloat16_wb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_flags = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [4:0]  wb_flags;
    logic        flush = 1'b0;
    logic        csr_we = 1'b0;
    logic [4:0]  csr_wdata = '0;
    logic [4:0]  fflags;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    logic [41:0] exp_q [$];

    dlfloat16_wb_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_rd     (in_rd),
        .in_flags  (in_flags),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .wb_flags  (wb_flags),
        .flush     (flush),
        .csr_we    (csr_we),
        .csr_wdata (csr_wdata),
        .fflags    (fflags),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every retirement is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && wb_valid && wb_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got data 0x%0h rd %0d with nothing expected", wb_data, wb_rd);
            end else begin
                logic [41:0] e;
                e = exp_q.pop_front();
                check("wb_data", wb_data, e[41:10]);
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e[9:5]});
                check("wb_flags", {27'd0, wb_flags}, {27'd0, e[4:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until accepted; records the expected entry on acceptance.
    task automatic push_one(input logic [31:0] d, input logic [4:0] r, input logic [4:0] f);
        bit done;
        done = 1'b0;
        in_valid  = 1'b1;
        in_result = d;
        in_rd     = r;
        in_flags  = f;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back({d, r, f});
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic drain();
        wb_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!wb_valid) break;
            tick();
        end
        wb_ready = 1'b0;
        check("drain_empty", {31'd0, wb_valid}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_fflags", {27'd0, fflags}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Three entries with wb stalled, then retire in order
        push_one(32'h0000_3C00, 5'd1, 5'b00000);
        push_one(32'h0000_4000, 5'd2, 5'b00001);
        push_one(32'h0000_BC00, 5'd3, 5'b00100);
        @(negedge clk);
        check("t1_count", {29'd0, count}, 32'd3);
        check("t1_wb_valid", {31'd0, wb_valid}, 32'd1);
        check("t1_head_data", wb_data, 32'h0000_3C00);
        check("t1_head_rd", {27'd0, wb_rd}, 32'd1);
        check("t1_fflags_no_push_accum", {27'd0, fflags}, 32'd0);
        tick();
        wb_ready = 1'b1;
        repeat (3) tick();
        wb_ready = 1'b0;
        @(negedge clk);
        check("t1_fflags", {27'd0, fflags}, 32'b00101);
        check("t1_count_end", {29'd0, count}, 32'd0);
        check("t1_wb_valid_end", {31'd0, wb_valid}, 32'd0);
        tick();

        // Fill, hold a 5th entry against full, pop one, drain across wrap
        for (int i = 1; i <= 4; i++) push_one(32'h1000 + i, 5'(i + 8), 5'b0);
        in_valid  = 1'b1;
        in_result = 32'h1005;
        in_rd     = 5'd13;
        in_flags  = 5'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t2_full_in_ready", {31'd0, in_ready}, 32'd0);
            check("t2_full_count", {29'd0, count}, 32'd4);
            tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        @(negedge clk);
        check("t2_ready_after_pop", {31'd0, in_ready}, 32'd1);
        check("t2_count_after_pop", {29'd0, count}, 32'd3);
        exp_q.push_back({32'h1005, 5'd13, 5'b0});
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_count_refill", {29'd0, count}, 32'd4);
        tick();
        drain();

        // Sustained push+pop at count=2
        push_one(32'h2000, 5'd20, 5'b0);
        push_one(32'h2001, 5'd21, 5'b0);
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_result = 32'h2002 + i;
            in_rd     = 5'(22 + i);
            in_flags  = 5'b0;
            @(negedge clk);
            check("t3_count_steady", {29'd0, count}, 32'd2);
            exp_q.push_back({32'h2002 + i, 5'(22 + i), 5'b0});
            tick();
        end
        in_valid = 1'b0;
        drain();

        // CSR write coincident with a retirement keeps the retiring flag
        csr_we    = 1'b1;
        csr_wdata = 5'b00001;
        tick();
        csr_we = 1'b0;
        @(negedge clk);
        check("t4_csr_write", {27'd0, fflags}, 32'b00001);
        tick();
        push_one(32'h0000_00AA, 5'd7, 5'b10000);
        csr_we    = 1'b1;
        csr_wdata = 5'b00000;
        wb_ready  = 1'b1;
        tick();
        csr_we   = 1'b0;
        wb_ready = 1'b0;
        @(negedge clk);
        check("t4_csr_plus_pop", {27'd0, fflags}, 32'b10000);
        check("t4_count", {29'd0, count}, 32'd0);
        tick();

        // Flush with concurrent push and pop requests
        push_one(32'h3000, 5'd1, 5'b0);
        push_one(32'h3001, 5'd2, 5'b0);
        push_one(32'h3002, 5'd3, 5'b0);
        @(negedge clk);
        check("t5_count_pre", {29'd0, count}, 32'd3);
        tick();
        in_valid  = 1'b1;
        in_result = 32'hDEAD;
        in_rd     = 5'd30;
        in_flags  = 5'b00010;
        wb_ready  = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        exp_q.delete();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        wb_ready = 1'b0;
        @(negedge clk);
        check("t5_count_flush", {29'd0, count}, 32'd0);
        check("t5_wb_valid_flush", {31'd0, wb_valid}, 32'd0);
        check("t5_fflags_kept", {27'd0, fflags}, 32'b10000);
        tick();
        push_one(32'h3100, 5'd4, 5'b0);
        drain();

        // Asynchronous reset mid-cycle
        csr_we    = 1'b1;
        csr_wdata = 5'b01000;
        push_one(32'h4000, 5'd5, 5'b0);
        csr_we = 1'b0;
        push_one(32'h4001, 5'd6, 5'b0);
        @(negedge clk);
        check("t6_count_pre", {29'd0, count}, 32'd2);
        check("t6_fflags_pre", {27'd0, fflags}, 32'b01000);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_count", {29'd0, count}, 32'd0);
        check("t6_async_fflags", {27'd0, fflags}, 32'd0);
        check("t6_async_in_ready", {31'd0, in_ready}, 32'd1);
        check("t6_async_wb_valid", {31'd0, wb_valid}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("t6_post_reset_count", {29'd0, count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dlfloat16_wb_queue.md
# dlfloat16_wb_queue

Result writeback buffer that sits directly downstream of the DLfloat16 FPU top. It captures each rounded 32-bit result, its destination register tag and its five exception flags into a small FIFO. It drains entries to the integer/FP register file over a valid/ready handshake and accumulates retired exception flags into a sticky fflags register, which software reads and writes.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  FPU result available this cycle
- in_ready  out  1  queue can accept (count < DEPTH)
- in_result  in  32  rounded result from FPU
- in_rd  in  5  destination register tag
- in_flags  in  5  {invalid, div_by_zero, overflow, underflow, inexact}
- wb_valid  out  1  head entry valid (count != 0)
- wb_ready  in  1  register file accepts head
- wb_data  out  32  head result
- wb_rd  out  5  head tag
- wb_flags  out  5  head flags
- flush  in  1  discard all queued entries
- csr_we  in  1  write fflags
- csr_wdata  in  5  fflags write value
- fflags  out  5  sticky accumulated flags, same bit order as in_flags
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- push = in_valid & in_ready & ~flush; pop = wb_valid & wb_ready & ~flush.
- Storage: DEPTH × 42 bits {result, rd, flags}; write pointer, read pointer, count; pointers wrap modulo DEPTH.
- Push writes entry at wr_ptr, increments wr_ptr. Pop increments rd_ptr. count += push − pop.
- wb_data/wb_rd/wb_flags: combinational read of entry at rd_ptr; don't-care when wb_valid=0 (bench must not check).
- Full (count=DEPTH): in_ready=0; in_valid ignored, no overwrite. No bypass: push and pop same cycle when full is impossible.
- Empty: wb_valid=0; wb_ready ignored, count never underflows.
- Push and pop same cycle (0<count<DEPTH): both occur, count unchanged.
- flush: next cycle count=0, rd_ptr=wr_ptr=0; same-cycle push and pop suppressed; fflags keeps its value (apart from a CSR write).
- fflags next = (csr_we ? csr_wdata : fflags) | (pop ? wb_flags : 5'b0). Flags accumulate only on retirement, never on push. CSR write in the same cycle as a pop keeps the retiring flags.
- Upstream holds in_result/in_rd/in_flags stable while in_valid=1 and in_ready=0; wb side may drop wb_ready at any time.

## Timing
- Reset (asserted asynchronously, any cycle, including mid-drain): count=0, pointers=0, fflags=0, wb_valid=0, in_ready=1. Storage contents are not reset.
- Latency: an entry pushed in cycle N is visible on wb_* with wb_valid=1 in cycle N+1 when the queue was empty.
- in_ready and wb_valid depend only on registered count; no combinational path from in_valid to in_ready or from wb_ready to wb_valid.
- fflags updates on the edge that ends the pop/CSR-write cycle.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then push 3 entries (result 0x00003C00/rd 1/flags 0, 0x00004000/rd 2/flags 5'b00001, 0x0000BC00/rd 3/flags 5'b00100), wb_ready=0 -> count=3, wb_data=0x00003C00, wb_rd=1, fflags=0. Then wb_ready=1 for 3 cycles -> entries retire in order, fflags=5'b00101, count=0, wb_valid=0.
- Fill DEPTH=4 with wb_ready=0, hold in_valid=1 with a 5th entry -> in_ready=0, count stays 4. Pop one -> 5th entry accepted the next cycle; drain order is 1..5 across pointer wrap.
- Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, outputs in FIFO order, no entry lost or duplicated.
- fflags=5'b00001, csr_we=1, csr_wdata=0, same cycle as pop of entry with flags 5'b10000 -> fflags=5'b10000 next cycle.
- count=3, flush=1 with in_valid=1 and wb_ready=1 -> next cycle count=0, wb_valid=0, fflags unchanged, pushed entry absent.
- Assert rst asynchronously mid-cycle with count=2, fflags=5'b01000 -> count=0, fflags=0, in_ready=1 immediately, without waiting for a clock edge.
